// File: rtl/fifo_1r1w_ctl_if.sv
// rtl/fifo_1r1w_ctl_if.sv - client and memory signal bundle for fifo_1r1w_ctl
interface fifo_1r1w_ctl_if #(
   parameter int BITADDR = 3,
   parameter int BITDATA = 1
);
   logic               ready;
   logic               push;
   logic [BITDATA-1:0] push_din;
   logic               pop;
   logic               pop_vld;
   logic [BITDATA-1:0] pop_dout;
   logic [BITADDR:0]   cnt;
   logic               full;
   logic               empty;
   logic [BITADDR:0]   wmark;
   logic               push_err;
   logic               pop_err;
   logic               mem_ready;
   logic               mem_read;
   logic [BITADDR-1:0] mem_rd_adr;
   logic [BITDATA-1:0] mem_rd_dout;
   logic               mem_write;
   logic [BITADDR-1:0] mem_wr_adr;
   logic [BITDATA-1:0] mem_wr_din;

   // controller view: client commands and memory responses come in
   modport slave (
      input  push, push_din, pop, mem_ready, mem_rd_dout,
      output ready, pop_vld, pop_dout, cnt, full, empty, wmark, push_err, pop_err,
             mem_read, mem_rd_adr, mem_write, mem_wr_adr, mem_wr_din
   );

   // client plus memory view: drives commands and memory responses
   modport master (
      output push, push_din, pop, mem_ready, mem_rd_dout,
      input  ready, pop_vld, pop_dout, cnt, full, empty, wmark, push_err, pop_err,
             mem_read, mem_rd_adr, mem_write, mem_wr_adr, mem_wr_din
   );
endinterface

// File: rtl/fifo_1r1w_ctl.sv
// rtl/fifo_1r1w_ctl.sv - FIFO controller over an external 1R1W memory
module fifo_1r1w_ctl #(
   parameter int NUMADDR    = 8,
   parameter int BITADDR    = 3,
   parameter int BITDATA    = 1,
   parameter int SRAM_DELAY = 0
) (
   input  logic           clk,
   input  logic           rst,
   fifo_1r1w_ctl_if.slave bus
);
   localparam int VLDW   = (SRAM_DELAY > 0) ? SRAM_DELAY : 1;
   localparam int LAST_I = NUMADDR - 1;
   localparam int ONE_I  = 1;
   localparam logic [BITADDR-1:0] LAST_ADR = LAST_I[BITADDR-1:0];
   localparam logic [BITADDR-1:0] ADR_ONE  = ONE_I[BITADDR-1:0];
   localparam logic [BITADDR:0]   FULL_CNT = NUMADDR[BITADDR:0];

   logic [BITADDR-1:0] wr_ptr_q, wr_ptr_d;
   logic [BITADDR-1:0] rd_ptr_q, rd_ptr_d;
   logic [BITADDR:0]   cnt_q, cnt_d;
   logic [BITADDR:0]   wmark_q, wmark_d;
   logic               push_err_q, push_err_d;
   logic               pop_err_q, pop_err_d;
   logic [VLDW-1:0]    vld_q, vld_d;

   logic full_int, empty_int;
   logic push_acc, push_rej, pop_acc, pop_rej;
   logic vld_out;

   // qualify commands against the registered occupancy; a same-cycle pop
   // never makes room for a push and a same-cycle push never feeds a pop
   always_comb begin
      full_int  = (cnt_q == FULL_CNT);
      empty_int = (cnt_q == '0);
      push_acc  = !rst && bus.push && bus.mem_ready && !full_int;
      push_rej  = !rst && bus.push && bus.mem_ready && full_int;
      pop_acc   = !rst && bus.pop  && bus.mem_ready && !empty_int;
      pop_rej   = !rst && bus.pop  && bus.mem_ready && empty_int;
   end

   // next-state for pointers, occupancy, watermark, sticky errors, valid pipe
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_acc) begin
         wr_ptr_d = (wr_ptr_q == LAST_ADR) ? '0 : wr_ptr_q + ADR_ONE;
      end
      if (pop_acc) begin
         rd_ptr_d = (rd_ptr_q == LAST_ADR) ? '0 : rd_ptr_q + ADR_ONE;
      end
      cnt_d      = cnt_q + {{BITADDR{1'b0}}, push_acc} - {{BITADDR{1'b0}}, pop_acc};
      wmark_d    = (cnt_d > wmark_q) ? cnt_d : wmark_q;
      push_err_d = push_err_q | push_rej;
      pop_err_d  = pop_err_q | pop_rej;
      vld_d      = vld_q << 1;
      vld_d[0]   = pop_acc;
   end

   // state registers; reset also flushes in-flight read valids
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         wmark_q    <= '0;
         push_err_q <= 1'b0;
         pop_err_q  <= 1'b0;
         vld_q      <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         wmark_q    <= wmark_d;
         push_err_q <= push_err_d;
         pop_err_q  <= pop_err_d;
         vld_q      <= vld_d;
      end
   end

   // zero-latency memories return data in the pop cycle itself
   always_comb begin
      if (SRAM_DELAY == 0) begin
         vld_out = pop_acc;
      end else begin
         vld_out = vld_q[VLDW-1] && !rst;
      end
   end

   assign bus.ready      = bus.mem_ready;
   assign bus.mem_write  = push_acc;
   assign bus.mem_wr_adr = push_acc ? wr_ptr_q : '0;
   assign bus.mem_wr_din = push_acc ? bus.push_din : '0;
   assign bus.mem_read   = pop_acc;
   assign bus.mem_rd_adr = pop_acc ? rd_ptr_q : '0;
   assign bus.pop_vld    = vld_out;
   assign bus.pop_dout   = vld_out ? bus.mem_rd_dout : '0;
   assign bus.cnt        = rst ? '0 : cnt_q;
   assign bus.wmark      = rst ? '0 : wmark_q;
   assign bus.full       = !rst && full_int;
   assign bus.empty      = rst || empty_int;
   assign bus.push_err   = !rst && push_err_q;
   assign bus.pop_err    = !rst && pop_err_q;
endmodule
